hazard_fwd_ctrl: RTL and testbench
==================================

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 bits each, source registers of the instruction currently in ID.
REQ-005 SHALL have port ex_q, input, id_ex_reg, the current ID/EX pipeline register contents.
REQ-006 SHALL have port mem_q, input, ex_mem_reg, the current EX/MEM pipeline register contents.
REQ-007 SHALL have port wb_q, input, mem_wb_reg, the current MEM/WB pipeline register contents.
REQ-008 SHALL have port redirect, input, 1 bit, taken branch or jump resolved in EX this cycle.
REQ-009 SHALL have port dmem_ready, input, 1 bit, data memory has completed the access held in EX/MEM.
REQ-010 SHALL have ports fwd_sel_a and fwd_sel_b, output, 2 bits each: 00 register file, 01 from MEM, 10 from WB.
REQ-011 SHALL have ports fwd_data_a and fwd_data_b, output, 32 bits each, selected bypass value for the EX operands.
REQ-012 SHALL have ports stall_if, stall_id, stall_ex and stall_mem, output, 1 bit each, hold the corresponding stage and its input register.
REQ-013 SHALL have ports flush_id and flush_ex, output, 1 bit each, load a bubble (all control bits 0) into IF/ID or ID/EX.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNT_W bits each, performance counters.

Function
REQ-015 SHALL forward operand A from MEM when mem_q.RegWrite=1, mem_q.rd!=0 and mem_q.rd=ex_q.RS_One; otherwise from WB when wb_q.RegWrite=1, wb_q.rd!=0 and wb_q.rd=ex_q.RS_One; otherwise select 00. Operand B follows the same rule with RS_Two.
REQ-016 SHALL take the MEM bypass value as mem_q.Pc_Four when mem_q.JalSel=1, else mem_q.Alu_Result.
REQ-017 SHALL take the WB bypass value as wb_q.MemReadData when wb_q.MemtoReg=1; else wb_q.Pc_Four when wb_q.JalSel=1; else wb_q.Alu_Result.
REQ-018 SHALL compute forwarding combinationally, with zero-cycle latency; fwd_data SHALL be 0 when fwd_sel=00.
REQ-019 SHALL implement the FSM states RUN, LOAD_STALL and MEM_WAIT.
REQ-020 SHALL detect a load-use hazard when ex_q.MemRead=1, ex_q.rd!=0 and ex_q.rd equals id_rs1 or id_rs2.
REQ-021 SHALL detect a memory wait when (mem_q.MemRead or mem_q.MemWrite)=1 and dmem_ready=0.
REQ-022 SHALL apply the following in RUN, with priority memory wait > redirect > load-use:
- memory wait: assert all four stalls; go to MEM_WAIT.
- redirect: assert flush_id and flush_ex; stay in RUN.
- load-use: assert stall_if, stall_id and flush_ex; go to LOAD_STALL.
REQ-023 SHALL spend exactly one cycle in LOAD_STALL, where no stall is asserted and the FSM returns to RUN; a load-use detected in this cycle SHALL be ignored.
REQ-024 SHALL hold all four stalls in MEM_WAIT while dmem_ready=0, and return to RUN with no stall in the cycle dmem_ready=1.
REQ-025 SHALL defer a redirect seen in MEM_WAIT: latch it and assert flush_id and flush_ex in the exit cycle.
REQ-026 SHALL increment stall_cnt in every cycle where any stall is asserted, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL increment flush_cnt once per cycle where flush_id is asserted, saturating at 2^CNT_W-1 with no wrap.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set the state to RUN, clear the deferred redirect, and clear stall_cnt and flush_cnt to 0.
REQ-029 SHALL, while reset=1, drive flush_id=flush_ex=1, all stalls 0 and fwd_sel 00; a reset arriving mid-stall or mid-wait SHALL abort that stall or wait.

Structure
REQ-030 SHALL take if_id_reg, id_ex_reg, ex_mem_reg and mem_wb_reg from Pipe_Buf_Reg_PKG.
REQ-031 SHALL add to that package the state enum hz_state_t and the fwd_sel encodings FWD_RF, FWD_MEM and FWD_WB.
REQ-032 SHALL instantiate one sub-module, fwd_mux, for each operand; it is purely combinational and covers REQ-015 to REQ-018.

Verification
REQ-033 Bench SHALL apply mem_q.RegWrite=1, rd=5, Alu_Result=0x10 and wb_q.RegWrite=1, rd=5, Alu_Result=0x20 with ex_q.RS_One=5 -> fwd_sel_a=01 and fwd_data_a=0x10.
REQ-034 Bench SHALL apply mem_q.rd=0 and RegWrite=1 with RS_One=0 -> fwd_sel_a=00.
REQ-035 Bench SHALL apply ex_q.MemRead=1, rd=3 with id_rs2=3 -> one cycle of stall_if=stall_id=flush_ex=1, next cycle no stall, stall_cnt=1.
REQ-036 Bench SHALL apply mem_q.MemRead=1 with dmem_ready=0 for 3 cycles and redirect=1 in cycle 2 -> 3 cycles of all stalls, then flush_id=flush_ex=1 on exit, flush_cnt=1.
REQ-037 Bench SHALL assert redirect=1 together with a load-use condition -> flush only, no stall, state stays RUN.
REQ-038 Bench SHALL assert reset during MEM_WAIT -> next cycle state RUN, counters 0, stalls 0.

Source files
------------

// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipeline buffer register types shared by the datapath and the hazard/forwarding control.
// Also holds the hazard FSM state type, the forwarding-select encodings and a small
// helper that decides whether a pipeline stage produces a given source register.
package Pipe_Buf_Reg_PKG;

  typedef struct packed {
    logic [31:0] Pc;
    logic [31:0] Pc_Four;
    logic [31:0] Instr;
  } if_id_reg;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemRead;
    logic        MemWrite;
    logic        JalSel;
    logic        ALUSrc;
    logic [4:0]  rd;
    logic [4:0]  RS_One;
    logic [4:0]  RS_Two;
    logic [31:0] Pc;
    logic [31:0] Pc_Four;
    logic [31:0] RD_One;
    logic [31:0] RD_Two;
    logic [31:0] ImmG;
  } id_ex_reg;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemRead;
    logic        MemWrite;
    logic        JalSel;
    logic [4:0]  rd;
    logic [31:0] Pc_Four;
    logic [31:0] Alu_Result;
    logic [31:0] RD_Two;
  } ex_mem_reg;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        JalSel;
    logic [4:0]  rd;
    logic [31:0] Pc_Four;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
  } mem_wb_reg;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // A stage supplies rs when it writes a non-zero destination equal to rs (x0 never forwards).
  function automatic logic src_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_mux.sv
// Operand bypass selector for one EX source operand (purely combinational).
// Ports:
//   rs       - source register number of the EX operand
//   mem_q    - EX/MEM pipeline register (youngest producer, highest priority)
//   wb_q     - MEM/WB pipeline register
//   fwd_sel  - 00 register file, 01 MEM bypass, 10 WB bypass
//   fwd_data - selected bypass value, 0 when the register file is selected
module fwd_mux
  import Pipe_Buf_Reg_PKG::*;
(
  input  logic [4:0]  rs,
  input  ex_mem_reg   mem_q,
  input  mem_wb_reg   wb_q,
  output logic [1:0]  fwd_sel,
  output logic [31:0] fwd_data
);

  always_comb begin
    fwd_sel  = FWD_RF;
    fwd_data = '0;
    if (src_hit(mem_q.RegWrite, mem_q.rd, rs)) begin
      fwd_sel  = FWD_MEM;
      fwd_data = mem_q.JalSel ? mem_q.Pc_Four : mem_q.Alu_Result;
    end else if (src_hit(wb_q.RegWrite, wb_q.rd, rs)) begin
      fwd_sel = FWD_WB;
      if (wb_q.MemtoReg) begin
        fwd_data = wb_q.MemReadData;
      end else if (wb_q.JalSel) begin
        fwd_data = wb_q.Pc_Four;
      end else begin
        fwd_data = wb_q.Alu_Result;
      end
    end
  end

  // Memory-side control and store data are not bypass sources.
  logic unused_mem;
  assign unused_mem = ^{mem_q.MemtoReg, mem_q.MemRead, mem_q.MemWrite, mem_q.RD_Two};

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection, stall/flush sequencing and operand forwarding for a 5-stage pipeline.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   id_rs1, id_rs2          - source registers of the instruction in ID
//   ex_q, mem_q, wb_q       - ID/EX, EX/MEM, MEM/WB pipeline register contents
//   redirect                - taken branch/jump resolved in EX
//   dmem_ready              - data memory finished the access held in EX/MEM
//   fwd_sel_a/b, fwd_data_a/b - EX operand bypass select and value
//   stall_if/id/ex/mem      - hold stage and its input register
//   flush_id, flush_ex      - load a bubble into IF/ID, ID/EX
//   stall_cnt, flush_cnt    - saturating performance counters
module hazard_fwd_ctrl
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  id_ex_reg         ex_q,
  input  ex_mem_reg        mem_q,
  input  mem_wb_reg        wb_q,
  input  logic             redirect,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [31:0]      fwd_data_a,
  output logic [31:0]      fwd_data_b,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  logic [1:0]  sel_a_raw, sel_b_raw;
  logic [31:0] data_a_raw, data_b_raw;

  fwd_mux u_fwd_a (
    .rs       (ex_q.RS_One),
    .mem_q    (mem_q),
    .wb_q     (wb_q),
    .fwd_sel  (sel_a_raw),
    .fwd_data (data_a_raw)
  );

  fwd_mux u_fwd_b (
    .rs       (ex_q.RS_Two),
    .mem_q    (mem_q),
    .wb_q     (wb_q),
    .fwd_sel  (sel_b_raw),
    .fwd_data (data_b_raw)
  );

  assign fwd_sel_a  = reset ? FWD_RF : sel_a_raw;
  assign fwd_sel_b  = reset ? FWD_RF : sel_b_raw;
  assign fwd_data_a = reset ? '0 : data_a_raw;
  assign fwd_data_b = reset ? '0 : data_b_raw;

  // ---------------------------------------------------------------------------
  // Hazard FSM
  // ---------------------------------------------------------------------------
  hz_state_t state_q, state_d;
  logic      redir_pend_q, redir_pend_d;
  logic      load_use, mem_wait;

  assign load_use = src_hit(ex_q.MemRead, ex_q.rd, id_rs1) |
                    src_hit(ex_q.MemRead, ex_q.rd, id_rs2);
  assign mem_wait = (mem_q.MemRead | mem_q.MemWrite) & ~dmem_ready;

  always_comb begin
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    if (reset) begin
      // Bubble both front registers so nothing half-fetched survives reset.
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (mem_wait) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
            state_d = StMemWait;
          end else if (redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = StLoadStall;
          end
        end
        StLoadStall: begin
          // The load has advanced to MEM; the dependent reads it via forwarding,
          // so a stale load-use match here is ignored.
          state_d = StRun;
          if (redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        StMemWait: begin
          if (!dmem_ready) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
            redir_pend_d = redir_pend_q | redirect;
          end else begin
            state_d      = StRun;
            redir_pend_d = 1'b0;
            if (redir_pend_q | redirect) begin
              flush_id = 1'b1;
              flush_ex = 1'b1;
            end
          end
        end
        default: begin
          state_d      = StRun;
          redir_pend_d = 1'b0;
        end
      endcase
    end
  end

  logic stall_any;
  assign stall_any = stall_if | stall_id | stall_ex | stall_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      redir_pend_q <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      if (stall_any && (stall_cnt != CntMax)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_id && (flush_cnt != CntMax)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // Only the hazard-relevant ID/EX fields are inspected here.
  logic unused_ex;
  assign unused_ex = ^{ex_q.RegWrite, ex_q.MemtoReg, ex_q.MemWrite, ex_q.JalSel, ex_q.ALUSrc,
                       ex_q.Pc, ex_q.Pc_Four, ex_q.RD_One, ex_q.RD_Two, ex_q.ImmG};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stall/flush/forward rules.
module tb_hazard_fwd_ctrl;
  import Pipe_Buf_Reg_PKG::*;

  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2;
  id_ex_reg      ex_q;
  ex_mem_reg     mem_q;
  mem_wb_reg     wb_q;
  logic          redirect, dmem_ready;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic [31:0]   fwd_data_a, fwd_data_b;
  logic          stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_fwd_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_q       (ex_q),
    .mem_q      (mem_q),
    .wb_q       (wb_q),
    .redirect   (redirect),
    .dmem_ready (dmem_ready),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .stall_ex   (stall_ex),
    .stall_mem  (stall_mem),
    .flush_id   (flush_id),
    .flush_ex   (flush_ex),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: pipeline "mode" flags and counters.
  bit   m_wait, m_ld, m_pend, n_wait, n_ld, n_pend;
  int   m_sc = 0, m_fc = 0;
  logic [3:0] e_stall;
  logic [1:0] e_flush;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest matching writer wins; x0 is never forwarded.
  function automatic logic [33:0] ref_fwd(input logic [4:0] rs);
    logic        wr  [2];
    logic [4:0]  rd  [2];
    logic [31:0] val [2];
    wr[0] = mem_q.RegWrite; rd[0] = mem_q.rd;
    val[0] = mem_q.JalSel ? mem_q.Pc_Four : mem_q.Alu_Result;
    wr[1] = wb_q.RegWrite;  rd[1] = wb_q.rd;
    val[1] = wb_q.MemtoReg ? wb_q.MemReadData : (wb_q.JalSel ? wb_q.Pc_Four : wb_q.Alu_Result);
    if (reset) return 34'd0;
    for (int k = 0; k < 2; k++) begin
      if (wr[k] && rd[k] != 5'd0 && rd[k] == rs) return {2'(k + 1), val[k]};
    end
    return 34'd0;
  endfunction

  task automatic check_now();
    bit lu, mw;
    logic [33:0] fa, fb;
    #1;
    lu = ex_q.MemRead && ex_q.rd != 5'd0 && (ex_q.rd == id_rs1 || ex_q.rd == id_rs2);
    mw = (mem_q.MemRead || mem_q.MemWrite) && !dmem_ready;
    e_stall = 4'b0000; e_flush = 2'b00;
    n_wait = m_wait; n_ld = 1'b0; n_pend = m_pend;
    if (reset) begin
      e_flush = 2'b11;
    end else if (m_wait) begin
      if (!dmem_ready) begin
        e_stall = 4'b1111;
        n_pend = m_pend | redirect;
      end else begin
        e_flush = (m_pend || redirect) ? 2'b11 : 2'b00;
        n_wait = 1'b0; n_pend = 1'b0;
      end
    end else if (m_ld) begin
      e_flush = redirect ? 2'b11 : 2'b00;
    end else if (mw) begin
      e_stall = 4'b1111; n_wait = 1'b1;
    end else if (redirect) begin
      e_flush = 2'b11;
    end else if (lu) begin
      e_stall = 4'b1100; e_flush = 2'b01; n_ld = 1'b1;
    end
    fa = ref_fwd(ex_q.RS_One);
    fb = ref_fwd(ex_q.RS_Two);
    chk("stalls", 64'({stall_if, stall_id, stall_ex, stall_mem}), 64'(e_stall));
    chk("flushes", 64'({flush_id, flush_ex}), 64'(e_flush));
    chk("fwd_a", 64'({fwd_sel_a, fwd_data_a}), 64'(fa));
    chk("fwd_b", 64'({fwd_sel_b, fwd_data_b}), 64'(fb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      m_wait = 0; m_ld = 0; m_pend = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_wait = n_wait; m_ld = n_ld; m_pend = n_pend;
      if (|e_stall && m_sc < CMAX) m_sc++;
      if (e_flush[1] && m_fc < CMAX) m_fc++;
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_fc));
    @(negedge clk);
  endtask

  task automatic cycle();
    check_now();
    tick();
  endtask

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; ex_q = '0; mem_q = '0; wb_q = '0;
    redirect = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    cycle();
    chk("rst_flush_id", 64'(flush_id), 64'd1);
    cycle();
    chk("rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
    idle();

    // MEM beats WB for the same rd.
    mem_q.RegWrite = 1; mem_q.rd = 5; mem_q.Alu_Result = 32'h10; mem_q.Pc_Four = 32'h44;
    wb_q.RegWrite = 1; wb_q.rd = 5; wb_q.Alu_Result = 32'h20;
    wb_q.MemReadData = 32'h30; wb_q.Pc_Four = 32'h50;
    ex_q.RS_One = 5; ex_q.RS_Two = 5;
    #1;
    chk("mem_pri_sel", 64'(fwd_sel_a), 64'd1);
    chk("mem_pri_data", 64'(fwd_data_a), 64'h10);
    cycle();
    mem_q.JalSel = 1; cycle();
    mem_q.RegWrite = 0; wb_q.MemtoReg = 1; cycle();
    wb_q.MemtoReg = 0; wb_q.JalSel = 1;
    #1;
    chk("wb_jal_data", 64'(fwd_data_b), 64'h50);
    cycle();

    // x0 is never forwarded.
    idle();
    mem_q.RegWrite = 1; mem_q.rd = 0; mem_q.Alu_Result = 32'h77;
    wb_q.RegWrite = 1; wb_q.rd = 0;
    #1;
    chk("x0_sel", 64'(fwd_sel_a), 64'd0);
    cycle();

    // Load-use: one stall cycle, then LOAD_STALL lets it go.
    do_reset();
    ex_q.MemRead = 1; ex_q.rd = 3; id_rs2 = 3;
    #1;
    chk("lu_stall", 64'({stall_if, stall_id, flush_ex, stall_ex}), 64'b1110);
    cycle();
    #1;
    chk("lu_release", 64'({stall_if, stall_id}), 64'd0);
    cycle();
    chk("lu_cnt", 64'(stall_cnt), 64'd1);

    // Memory wait with a redirect deferred to the exit cycle.
    do_reset();
    mem_q.MemRead = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      redirect = (i == 1);
      #1;
      chk("mw_stall", 64'({stall_if, stall_id, stall_ex, stall_mem, flush_id}), 64'b11110);
      cycle();
    end
    redirect = 0; dmem_ready = 1;
    #1;
    chk("mw_exit", 64'({stall_if, stall_mem, flush_id, flush_ex}), 64'b0011);
    cycle();
    chk("mw_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("mw_stall_cnt", 64'(stall_cnt), 64'd3);

    // Redirect outranks load-use; state stays RUN so the next load-use stalls.
    do_reset();
    ex_q.MemRead = 1; ex_q.rd = 3; id_rs1 = 3; redirect = 1;
    #1;
    chk("rd_lu", 64'({stall_if, stall_id, flush_id, flush_ex}), 64'b0011);
    cycle();
    redirect = 0;
    #1;
    chk("rd_lu_run", 64'({stall_if, stall_id}), 64'b11);
    cycle();

    // Reset aborts a memory wait.
    do_reset();
    mem_q.MemWrite = 1; dmem_ready = 0;
    cycle(); cycle();
    reset = 1;
    #1;
    chk("rst_mw", 64'({stall_if, stall_mem, flush_id}), 64'b001);
    cycle();
    idle(); dmem_ready = 0;
    #1;
    chk("post_rst_run", 64'({stall_if, stall_id, stall_ex, stall_mem}), 64'd0);
    chk("post_rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
    cycle();

    // Counter saturation.
    idle();
    mem_q.MemRead = 1; dmem_ready = 0;
    for (int i = 0; i < CMAX + 5; i++) cycle();
    chk("stall_sat", 64'(stall_cnt), 64'(CMAX));
    idle(); redirect = 1;
    for (int i = 0; i < CMAX + 5; i++) cycle();
    chk("flush_sat", 64'(flush_cnt), 64'(CMAX));

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_q = '0;
      ex_q.MemRead = 1'($urandom_range(0, 1));
      ex_q.rd = 5'($urandom_range(0, 3));
      ex_q.RS_One = 5'($urandom_range(0, 3));
      ex_q.RS_Two = 5'($urandom_range(0, 3));
      mem_q = '0;
      mem_q.RegWrite = 1'($urandom_range(0, 1));
      mem_q.rd = 5'($urandom_range(0, 3));
      mem_q.JalSel = 1'($urandom_range(0, 1));
      mem_q.MemRead = ($urandom_range(0, 3) == 0);
      mem_q.MemWrite = ($urandom_range(0, 3) == 0);
      mem_q.Pc_Four = $urandom;
      mem_q.Alu_Result = $urandom;
      wb_q = '0;
      wb_q.RegWrite = 1'($urandom_range(0, 1));
      wb_q.rd = 5'($urandom_range(0, 3));
      wb_q.MemtoReg = 1'($urandom_range(0, 1));
      wb_q.JalSel = 1'($urandom_range(0, 1));
      wb_q.Pc_Four = $urandom;
      wb_q.Alu_Result = $urandom;
      wb_q.MemReadData = $urandom;
      redirect = ($urandom_range(0, 4) == 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
